// File: rtl/dmem_access_arbiter.sv
// Round-robin arbiter sharing a byte-wide data memory between a processor (A) and a debug
// loader (B); word requests are split into four big-endian byte beats.
module dmem_access_arbiter #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              a_req,
  input  logic              a_we,
  input  logic              a_word,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [31:0]       a_wdata,
  output logic              a_ack,
  output logic [31:0]       a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic              b_word,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [31:0]       b_wdata,
  output logic              b_ack,
  output logic [31:0]       b_rdata,
  output logic              busy,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e              state_q, state_d;
  logic [1:0]          beat_q, beat_d;
  logic                last_b_q, last_b_d;
  logic                port_b_q, port_b_d;
  logic                we_q, we_d;
  logic                word_q, word_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [2:0][7:0]     sh_q, sh_d;
  logic                a_ack_q, a_ack_d;
  logic                b_ack_q, b_ack_d;
  logic [31:0]         a_rdata_q, a_rdata_d;
  logic [31:0]         b_rdata_q, b_rdata_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]          mem_wdata_q, mem_wdata_d;

  // Grant selection: B wins when alone, or when both request and A had the last grant.
  logic                grant_b;
  logic                sel_we;
  logic                sel_word;
  logic [ADDR_W-1:0]   sel_addr;
  logic [31:0]         sel_wdata;
  logic                last_beat;
  logic [1:0]          beat_nxt;
  logic [31:0]         load_val;

  always_comb begin
    grant_b   = b_req & (~a_req | ~last_b_q);
    sel_we    = grant_b ? b_we    : a_we;
    sel_word  = grant_b ? b_word  : a_word;
    sel_addr  = grant_b ? b_addr  : a_addr;
    sel_wdata = grant_b ? b_wdata : a_wdata;
    last_beat = word_q ? (beat_q == 2'd3) : 1'b1;
    beat_nxt  = beat_q + 2'd1;
    // Final byte comes straight from memory so rdata is valid in the DONE cycle.
    load_val  = word_q ? {sh_q[0], sh_q[1], sh_q[2], mem_rdata}
                       : {{24{mem_rdata[7]}}, mem_rdata};
  end

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    last_b_d    = last_b_q;
    port_b_d    = port_b_q;
    we_d        = we_q;
    word_d      = word_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    sh_d        = sh_q;
    a_ack_d     = 1'b0;
    b_ack_d     = 1'b0;
    a_rdata_d   = a_rdata_q;
    b_rdata_d   = b_rdata_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    unique case (state_q)
      StIdle: begin
        if (a_req || b_req) begin
          port_b_d    = grant_b;
          last_b_d    = grant_b;
          we_d        = sel_we;
          word_d      = sel_word;
          addr_d      = sel_addr;
          wdata_d     = sel_wdata;
          beat_d      = 2'd0;
          state_d     = StAccess;
          mem_we_d    = sel_we;
          mem_addr_d  = sel_addr;
          mem_wdata_d = sel_word ? sel_wdata[31:24] : sel_wdata[7:0];
        end
      end

      StAccess: begin
        if (!we_q) begin
          unique case (beat_q)
            2'd0:    sh_d[0] = mem_rdata;
            2'd1:    sh_d[1] = mem_rdata;
            2'd2:    sh_d[2] = mem_rdata;
            default: ;
          endcase
        end
        if (last_beat) begin
          state_d = StDone;
          if (port_b_q) begin
            b_ack_d = 1'b1;
            if (!we_q) b_rdata_d = load_val;
          end else begin
            a_ack_d = 1'b1;
            if (!we_q) a_rdata_d = load_val;
          end
        end else begin
          beat_d     = beat_nxt;
          mem_we_d   = we_q;
          mem_addr_d = addr_q + ADDR_W'(beat_nxt);
          unique case (beat_nxt)
            2'd1:    mem_wdata_d = wdata_q[23:16];
            2'd2:    mem_wdata_d = wdata_q[15:8];
            2'd3:    mem_wdata_d = wdata_q[7:0];
            default: mem_wdata_d = wdata_q[31:24];
          endcase
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= StIdle;
      beat_q      <= 2'd0;
      last_b_q    <= 1'b1;
      port_b_q    <= 1'b0;
      we_q        <= 1'b0;
      word_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      sh_q        <= '0;
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      last_b_q    <= last_b_d;
      port_b_q    <= port_b_d;
      we_q        <= we_d;
      word_q      <= word_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      sh_q        <= sh_d;
      a_ack_q     <= a_ack_d;
      b_ack_q     <= b_ack_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign a_ack     = a_ack_q;
  assign b_ack     = b_ack_q;
  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_access_arbiter.sv
// Directed bench for dmem_access_arbiter with a negedge-write byte memory model.
module tb_dmem_access_arbiter;

  logic        CLK;
  logic        RST_N;
  logic        a_req, a_we, a_word;
  logic [11:0] a_addr;
  logic [31:0] a_wdata;
  logic        a_ack;
  logic [31:0] a_rdata;
  logic        b_req, b_we, b_word;
  logic [11:0] b_addr;
  logic [31:0] b_wdata;
  logic        b_ack;
  logic [31:0] b_rdata;
  logic        busy;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic [7:0]  mem [4096];

  int total;
  int bad;

  dmem_access_arbiter #(.ADDR_W(12)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .a_req     (a_req),
    .a_we      (a_we),
    .a_word    (a_word),
    .a_addr    (a_addr),
    .a_wdata   (a_wdata),
    .a_ack     (a_ack),
    .a_rdata   (a_rdata),
    .b_req     (b_req),
    .b_we      (b_we),
    .b_word    (b_word),
    .b_addr    (b_addr),
    .b_wdata   (b_wdata),
    .b_ack     (b_ack),
    .b_rdata   (b_rdata),
    .busy      (busy),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) if (mem_we) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    a_req = 1'b0;
    b_req = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  // Waits for IDLE, issues one request, returns edges-to-ack counted from the grant edge.
  task automatic xfer(input bit port_b, input bit we, input bit word, input logic [11:0] addr,
                      input logic [31:0] wdata, output int lat, output bit other_ack);
    bit got;
    @(negedge CLK);
    for (int i = 0; i < 50 && busy; i++) @(negedge CLK);
    if (port_b) begin
      b_req = 1'b1; b_we = we; b_word = word; b_addr = addr; b_wdata = wdata;
    end else begin
      a_req = 1'b1; a_we = we; a_word = word; a_addr = addr; a_wdata = wdata;
    end
    lat = 0;
    other_ack = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge CLK);
      #1;
      lat++;
      if (port_b ? a_ack : b_ack) other_ack = 1'b1;
      if (port_b ? b_ack : a_ack) got = 1'b1;
    end
    if (!got) lat = 99;
    a_req = 1'b0;
    b_req = 1'b0;
  endtask

  int          lat;
  bit          oth;
  int          na, nb, nack;
  logic [5:0]  order;

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h5A;
    RST_N = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_word = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_word = 1'b0; b_addr = '0; b_wdata = '0;
    repeat (3) @(posedge CLK);
    #1;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_mem_we", 32'(mem_we), 32'd0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_acks", {30'd0, a_ack, b_ack}, 32'd0);
    check_eq("rst_a_rdata", a_rdata, 32'd0);
    check_eq("rst_b_rdata", b_rdata, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    // Word store then load
    xfer(1'b0, 1'b1, 1'b1, 12'h010, 32'hDEADBEEF, lat, oth);
    check_eq("t1_lat", 32'(lat), 32'd5);
    check_eq("t1_mem", {mem[12'h010], mem[12'h011], mem[12'h012], mem[12'h013]}, 32'hDEADBEEF);
    @(posedge CLK);
    #1;
    check_eq("t1_ack_pulse", 32'(a_ack), 32'd0);
    xfer(1'b0, 1'b0, 1'b1, 12'h010, 32'h0, lat, oth);
    check_eq("t2_lat", 32'(lat), 32'd5);
    check_eq("t2_rdata", a_rdata, 32'hDEADBEEF);
    check_eq("t2_b_ack", 32'(oth), 32'd0);

    // Byte store/load on B with sign extension
    xfer(1'b1, 1'b1, 1'b0, 12'h020, 32'h12345680, lat, oth);
    check_eq("t3_st_lat", 32'(lat), 32'd2);
    check_eq("t3_mem", 32'(mem[12'h020]), 32'h80);
    check_eq("t3_mem_next", 32'(mem[12'h021]), 32'h5A);
    xfer(1'b1, 1'b0, 1'b0, 12'h020, 32'h0, lat, oth);
    check_eq("t3_ld_lat", 32'(lat), 32'd2);
    check_eq("t3_rdata", b_rdata, 32'hFFFFFF80);
    check_eq("t3_a_rdata_kept", a_rdata, 32'hDEADBEEF);

    // Contention: alternating grants starting with A after reset
    do_reset();
    mem[12'h030] = 8'h7F;
    mem[12'h031] = 8'h81;
    a_we = 1'b0; a_word = 1'b0; a_addr = 12'h030;
    b_we = 1'b0; b_word = 1'b0; b_addr = 12'h031;
    a_req = 1'b1;
    b_req = 1'b1;
    na = 0;
    nb = 0;
    order = '0;
    for (int i = 0; i < 100 && (na < 3 || nb < 3); i++) begin
      @(posedge CLK);
      #1;
      if (a_ack) begin
        order = {order[4:0], 1'b1};
        na++;
        if (na == 3) a_req = 1'b0;
      end
      if (b_ack) begin
        order = {order[4:0], 1'b0};
        nb++;
        if (nb == 3) b_req = 1'b0;
      end
    end
    a_req = 1'b0;
    b_req = 1'b0;
    check_eq("t4_order", 32'(order), 32'b101010);
    check_eq("t4_counts", 32'(na * 16 + nb), 32'h33);
    check_eq("t4_a_rdata", a_rdata, 32'h0000007F);
    check_eq("t4_b_rdata", b_rdata, 32'hFFFFFF81);

    // Address wrap-around
    xfer(1'b0, 1'b1, 1'b1, 12'hFFE, 32'h11223344, lat, oth);
    check_eq("t5_mem", {mem[12'hFFE], mem[12'hFFF], mem[12'h000], mem[12'h001]}, 32'h11223344);
    xfer(1'b0, 1'b0, 1'b1, 12'hFFE, 32'h0, lat, oth);
    check_eq("t5_rdata", a_rdata, 32'h11223344);

    // Reset after two beats of a word store
    @(negedge CLK);
    for (int i = 0; i < 50 && busy; i++) @(negedge CLK);
    a_req = 1'b1; a_we = 1'b1; a_word = 1'b1; a_addr = 12'h100; a_wdata = 32'hCAFEF00D;
    @(posedge CLK);
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b0;
    a_req = 1'b0;
    @(posedge CLK);
    #1;
    check_eq("t6_busy", 32'(busy), 32'd0);
    check_eq("t6_mem_we", 32'(mem_we), 32'd0);
    nack = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK);
      #1;
      if (a_ack || mem_we) nack++;
    end
    check_eq("t6_no_ack", 32'(nack), 32'd0);
    check_eq("t6_a_rdata", a_rdata, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    check_eq("t6_mem", {mem[12'h100], mem[12'h101], mem[12'h102], mem[12'h103]}, 32'hCAFE5A5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
